// File: rtl/submod_result_merge.sv
// Merges two submod result lanes through per-lane FIFOs into one registered,
// round-robin arbitrated output stream tagged with the source lane.

module submod_result_merge_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  // Full is judged on the registered count alone, so a same-cycle pop never frees a slot.
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rp_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (do_push) wp_d = wp_q + AW'(1);
    if (do_pop)  rp_d = rp_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= data_i;
  end
endmodule

module submod_result_merge #(
  parameter int WIDTH0 = 4,
  parameter int WIDTH1 = 3,
  parameter int DEPTH  = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in0_valid,
  output logic                                          in0_ready,
  input  logic [WIDTH0-1:0]                             in0_data,
  input  logic                                          in1_valid,
  output logic                                          in1_ready,
  input  logic [WIDTH1-1:0]                             in1_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [((WIDTH0 > WIDTH1) ? WIDTH0 : WIDTH1)-1:0] out_data,
  output logic                                          out_lane
);
  localparam int OUT_W = (WIDTH0 > WIDTH1) ? WIDTH0 : WIDTH1;

  // Handshakes: a word moves on a rising edge where valid && ready are both high;
  // the producer holds data stable while valid && !ready.
  logic              full0, full1;
  logic              empty0, empty1;
  logic [WIDTH0-1:0] head0;
  logic [WIDTH1-1:0] head1;
  logic              pop0, pop1;
  logic              ld;
  logic              grant0, grant1;

  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              out_lane_q, out_lane_d;
  logic              last_grant_q, last_grant_d;

  submod_result_merge_fifo #(.W(WIDTH0), .DEPTH(DEPTH)) u_fifo0 (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in0_valid),
    .data_i  (in0_data),
    .pop_i   (pop0),
    .full_o  (full0),
    .empty_o (empty0),
    .head_o  (head0)
  );

  submod_result_merge_fifo #(.W(WIDTH1), .DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in1_valid),
    .data_i  (in1_data),
    .pop_i   (pop1),
    .full_o  (full1),
    .empty_o (empty1),
    .head_o  (head1)
  );

  assign in0_ready = !full0;
  assign in1_ready = !full1;

  // Under contention the lane that did not win last time goes next.
  assign ld     = !out_valid_q || out_ready;
  assign grant0 = !empty0 && (empty1 || last_grant_q);
  assign grant1 = !empty1 && (empty0 || !last_grant_q);
  assign pop0   = ld && grant0;
  assign pop1   = ld && grant1;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_lane_d   = out_lane_q;
    last_grant_d = last_grant_q;
    if (ld) begin
      out_valid_d = 1'b0;
      if (grant0) begin
        out_valid_d  = 1'b1;
        out_data_d   = OUT_W'(head0);
        out_lane_d   = 1'b0;
        last_grant_d = 1'b0;
      end else if (grant1) begin
        out_valid_d  = 1'b1;
        out_data_d   = OUT_W'(head1);
        out_lane_d   = 1'b1;
        last_grant_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_lane_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_lane_q   <= out_lane_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lane  = out_lane_q;
endmodule

// File: tb/tb_submod_result_merge.sv
// Directed and randomized checks of submod_result_merge against per-lane
// expected queues plus explicit output-order tables.

module tb_submod_result_merge;
  localparam int W0    = 4;
  localparam int W1    = 3;
  localparam int DEPTH = 4;
  localparam int OW    = 4;

  logic          clk;
  logic          rst;
  logic          in0_valid, in0_ready;
  logic [W0-1:0] in0_data;
  logic          in1_valid, in1_ready;
  logic [W1-1:0] in1_data;
  logic          out_valid, out_ready;
  logic [OW-1:0] out_data;
  logic          out_lane;

  int n_vec = 0;
  int n_err = 0;

  logic [W0-1:0] exp0_q[$];
  logic [W1-1:0] exp1_q[$];
  logic [4:0]    log_q[$];

  submod_result_merge #(.WIDTH0(W0), .WIDTH1(W1), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_data  (in0_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lane  (out_lane)
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: inputs and outputs sampled on the falling edge, ahead of the edge that acts on them
  always @(negedge clk) begin
    if (rst) begin
      exp0_q.delete();
      exp1_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        log_q.push_back({out_lane, out_data});
        if (!out_lane) begin
          check("lane0_word_expected", exp0_q.size() != 0, 1);
          if (exp0_q.size() != 0) check("lane0_data", out_data, exp0_q.pop_front());
        end else begin
          check("lane1_word_expected", exp1_q.size() != 0, 1);
          check("lane1_upper_zero", out_data[3], 0);
          if (exp1_q.size() != 0) check("lane1_data", out_data, exp1_q.pop_front());
        end
      end
      if (in0_valid && in0_ready) exp0_q.push_back(in0_data);
      if (in1_valid && in1_ready) exp1_q.push_back(in1_data);
      check("lane0_occupancy", exp0_q.size() <= DEPTH + 1, 1);
      check("lane1_occupancy", exp1_q.size() <= DEPTH + 1, 1);
    end
  end

  // driver tasks
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  task automatic push_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      in0_valid = 1'b1;
      in0_data  = W0'(i + 1);
      in1_valid = 1'b1;
      in1_data  = W1'(i + 5);
      tick();
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (!out_valid && exp0_q.size() == 0 && exp1_q.size() == 0) break;
      tick();
    end
    check({tag, "_out_idle"}, out_valid, 0);
    check({tag, "_lane0_drained"}, exp0_q.size(), 0);
    check({tag, "_lane1_drained"}, exp1_q.size(), 0);
  endtask

  task automatic rand_stream(input int n0, input int n1, input int budget, input int rdy_pct);
    int   a0 = 0;
    int   a1 = 0;
    int   cyc = 0;
    logic st0 = 1'b0;
    logic st1 = 1'b0;
    while ((a0 < n0 || a1 < n1) && cyc < budget) begin
      if (!st0) begin
        in0_valid = (a0 < n0) && ($urandom_range(0, 3) != 0);
        in0_data  = W0'($urandom_range(0, 15));
      end
      if (!st1) begin
        in1_valid = (a1 < n1) && ($urandom_range(0, 3) != 0);
        in1_data  = W1'($urandom_range(0, 7));
      end
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      st0 = in0_valid && !in0_ready;
      st1 = in1_valid && !in1_ready;
      if (in0_valid && in0_ready) a0++;
      if (in1_valid && in1_ready) a1++;
      tick();
      cyc++;
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    check("stream_lane0_accepted", a0, n0);
    check("stream_lane1_accepted", a1, n1);
  endtask

  logic [4:0] exp_contend [6];
  int         lane0_seen;

  initial begin
    exp_contend = '{5'h01, 5'h15, 5'h02, 5'h16, 5'h03, 5'h17};
    in0_data  = '0;
    in1_data  = '0;
    out_ready = 1'b0;

    // reset
    do_reset(2);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_lane", out_lane, 0);
    check("rst_in0_ready", in0_ready, 1);
    check("rst_in1_ready", in1_ready, 1);

    // single word latency
    out_ready = 1'b1;
    in0_valid = 1'b1;
    in0_data  = 4'hA;
    tick();
    in0_valid = 1'b0;
    check("single_no_bypass", out_valid, 0);
    tick();
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 4'hA);
    check("single_lane", out_lane, 0);
    tick();
    check("single_gone", out_valid, 0);

    // contention from a fresh reset: lane 0 wins the first tie
    do_reset(1);
    out_ready = 1'b0;
    push_pairs(3);
    check("contend_stalled_data", out_data, 1);
    check("contend_stalled_lane", out_lane, 0);
    log_q.delete();
    drain("contend");
    check("contend_count", log_q.size(), 6);
    for (int i = 0; i < 6; i++) check("contend_order", log_q[i], exp_contend[i]);

    // full lane and backpressure
    log_q.delete();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in1_valid = 1'b1;
      in1_data  = W1'(i);
      tick();
    end
    check("full_in1_ready", in1_ready, 0);
    check("full_in0_ready", in0_ready, 1);
    check("full_hold_data", out_data, 1);
    check("full_hold_lane", out_lane, 1);
    in1_data = 3'd6;
    tick();
    check("full_still_blocked", in1_ready, 0);
    check("full_hold_data2", out_data, 1);
    out_ready = 1'b1;
    tick();
    in1_valid = 1'b0;
    check("full_pop_frees_next", in1_ready, 1);
    drain("full");
    check("full_count", log_q.size(), 5);
    for (int i = 0; i < 5; i++) check("full_order", log_q[i], 5'h10 | 5'(i + 1));

    // pointer wrap on lane 0 with random backpressure
    log_q.delete();
    rand_stream(3 * DEPTH, 0, 400, 50);
    drain("wrap");
    lane0_seen = 0;
    foreach (log_q[i]) if (!log_q[i][4]) lane0_seen++;
    check("wrap_count", lane0_seen, 3 * DEPTH);

    // randomized mixed traffic
    rand_stream(40, 40, 800, 60);
    drain("mixed");

    // reset in the middle of stalled traffic
    out_ready = 1'b0;
    push_pairs(3);
    check("midrst_pre_valid", out_valid, 1);
    do_reset(1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_in0_ready", in0_ready, 1);
    check("midrst_in1_ready", in1_ready, 1);
    in0_valid = 1'b1;
    in0_data  = 4'h9;
    out_ready = 1'b1;
    tick();
    in0_valid = 1'b0;
    check("midrst_no_stale", out_valid, 0);
    tick();
    check("midrst_new_valid", out_valid, 1);
    check("midrst_new_data", out_data, 4'h9);
    check("midrst_new_lane", out_lane, 0);
    tick();
    check("midrst_then_idle", out_valid, 0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
